// File: rtl/sdram_slave_responder.sv
//------------------------------------------------------------------------------
// Module      : sdram_slave_responder
// Description : Avalon-MM style 16-bit memory responder with wait-state
//               insertion, pipelined read latency, transfer counters and a
//               sticky protocol-error flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdram_slave_responder #(
    parameter int DEPTH        = 64,
    parameter int WAIT_CYCLES  = 1,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] sdr_slave_address,
    input  logic [1:0]  sdr_slave_byteenable_n,
    input  logic        sdr_slave_chipselect,
    input  logic [15:0] sdr_slave_writedata,
    input  logic        sdr_slave_read_n,
    input  logic        sdr_slave_write_n,
    output logic [15:0] sdr_slave_readdata,
    output logic        sdr_slave_readdatavalid,
    output logic        sdr_slave_waitrequest,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        proto_err
);

    localparam int         c_AW   = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    generate
        if ((DEPTH < 2) || ((1 << c_AW) != DEPTH)) begin : g_bad_depth
            $error("DEPTH must be a power of two, at least 2");
        end
        if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
            $error("WAIT_CYCLES must be in 0..15");
        end
        if ((READ_LATENCY < 1) || (READ_LATENCY > 8)) begin : g_bad_latency
            $error("READ_LATENCY must be in 1..8");
        end
    endgenerate

    logic [3:0]              r_cnt;
    logic [15:0]             r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_vld;
    logic [15:0]             r_data [READ_LATENCY];
    logic [15:0]             r_wr_count;
    logic [15:0]             r_rd_count;
    logic                    r_proto_err;

    logic                    w_req;
    logic                    w_wait;
    logic                    w_accept;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_proto;
    logic [c_AW-1:0]         w_idx;
    logic                    w_unused_addr;

    assign w_idx         = sdr_slave_address[c_AW-1:0];
    assign w_unused_addr = ^sdr_slave_address[24:c_AW];

    assign w_req    = sdr_slave_chipselect & (~sdr_slave_read_n | ~sdr_slave_write_n);
    // Holding reset in the expression keeps waitrequest high while in reset,
    // even for WAIT_CYCLES = 0.
    assign w_wait   = ~(reset & w_req & (r_cnt == c_WAIT));
    assign w_accept = w_req & ~w_wait;
    assign w_wr     = w_accept & ~sdr_slave_write_n;
    assign w_rd     = w_accept & sdr_slave_write_n & ~sdr_slave_read_n;
    assign w_proto  = w_wr & ~sdr_slave_read_n;

    // Saturating counter: a held request streams once it reaches WAIT_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!w_req) begin
            r_cnt <= '0;
        end else if (r_cnt < c_WAIT) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            if (!sdr_slave_byteenable_n[0]) begin
                r_mem[w_idx][7:0] <= sdr_slave_writedata[7:0];
            end
            if (!sdr_slave_byteenable_n[1]) begin
                r_mem[w_idx][15:8] <= sdr_slave_writedata[15:8];
            end
        end
    end

    // Data is captured at acceptance; empty slots carry zero so readdata is
    // zero whenever readdatavalid is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= w_rd;
            r_data[0] <= w_rd ? r_mem[w_idx] : 16'h0000;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_count  <= '0;
            r_rd_count  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_rd) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_proto) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign sdr_slave_waitrequest   = w_wait;
    assign sdr_slave_readdatavalid = r_vld[READ_LATENCY-1];
    assign sdr_slave_readdata      = r_data[READ_LATENCY-1];
    assign wr_count                = r_wr_count;
    assign rd_count                = r_rd_count;
    assign proto_err               = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_sdram_slave_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_sdram_slave_responder
// Description : Self-checking bench for sdram_slave_responder, three parameter
//               sets against a transaction-level reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sdram_slave_responder;

    localparam int         NI   = 3;
    localparam logic [11:0] c_WV = {4'd3, 4'd0, 4'd1};
    localparam logic [11:0] c_LV = {4'd4, 4'd1, 4'd2};

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] addr;
    logic [1:0]  be_n;
    logic [15:0] wdata;
    logic        read_n;
    logic        write_n;
    logic [NI-1:0] cs;
    logic [15:0] rdata [NI];
    logic [15:0] wrc [NI];
    logic [15:0] rdc [NI];
    logic [NI-1:0] rdv;
    logic [NI-1:0] wreq;
    logic [NI-1:0] perr;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            sdram_slave_responder #(
                .DEPTH        (64),
                .WAIT_CYCLES  (int'(c_WV[g*4 +: 4])),
                .READ_LATENCY (int'(c_LV[g*4 +: 4]))
            ) u_dut (
                .clk                     (clk),
                .reset                   (reset),
                .sdr_slave_address       (addr),
                .sdr_slave_byteenable_n  (be_n),
                .sdr_slave_chipselect    (cs[g]),
                .sdr_slave_writedata     (wdata),
                .sdr_slave_read_n        (read_n),
                .sdr_slave_write_n       (write_n),
                .sdr_slave_readdata      (rdata[g]),
                .sdr_slave_readdatavalid (rdv[g]),
                .sdr_slave_waitrequest   (wreq[g]),
                .wr_count                (wrc[g]),
                .rd_count                (rdc[g]),
                .proto_err               (perr[g])
            );
        end
    endgenerate

    typedef struct {
        bit          cs;
        bit          rd;
        bit          wr;
        logic [24:0] addr;
        logic [1:0]  be;
        logic [15:0] data;
    } req_t;

    typedef struct {
        int          due;
        logic [15:0] d;
    } rsp_t;

    int errors = 0;
    int checks = 0;

    // Reference model state
    req_t        q[$];
    rsp_t        pend[$];
    int          m_cyc = 0;
    int          m_run = 0;
    logic [15:0] m_mem [NI][64];
    logic [15:0] m_wr [NI] = '{default: 16'h0};
    logic [15:0] m_rd [NI] = '{default: 16'h0};
    bit          m_pe [NI] = '{default: 1'b0};
    bit          m_acc;
    bit          m_req;

    logic        o_wait, o_rdv, o_pe, e_wait, e_rdv, e_pe;
    logic [15:0] o_rd, o_wrc, o_rdc, e_rd, e_wrc, e_rdc;

    // Per-run observations
    int          st_stall;
    int          st_acc;
    int          st_rdv;
    int          st_rdv_last;
    int          st_rdv_n;
    bit          st_first_wait;
    logic [15:0] st_data[$];

    function automatic int wait_of(input int g);
        return int'(c_WV[g*4 +: 4]);
    endfunction

    function automatic int lat_of(input int g);
        return int'(c_LV[g*4 +: 4]);
    endfunction

    function automatic req_t mk(input bit c, input bit r, input bit w, input logic [24:0] a,
                                input logic [1:0] b, input logic [15:0] d);
        req_t t;
        t.cs = c; t.rd = r; t.wr = w; t.addr = a; t.be = b; t.data = d;
        return t;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_run = 0;
        for (int g = 0; g < NI; g++) begin
            m_wr[g] = 16'h0;
            m_rd[g] = 16'h0;
            m_pe[g] = 1'b0;
        end
    endtask

    // Present the head of the queue; while a stall is predicted the
    // address/data are scrambled, which the responder must ignore.
    task automatic drive_next(input int g);
        req_t r;
        cs = '0;
        if (q.size() == 0) begin
            read_n  = 1'b1;
            write_n = 1'b1;
            return;
        end
        r       = q[0];
        cs[g]   = r.cs;
        read_n  = !r.rd;
        write_n = !r.wr;
        if (r.cs && (r.rd || r.wr) && (m_run < wait_of(g))) begin
            addr  = 25'($urandom);
            wdata = 16'($urandom);
            be_n  = 2'($urandom);
        end else begin
            addr  = r.addr;
            wdata = r.data;
            be_n  = r.be;
        end
    endtask

    // Advance one clock: sample outputs, form model expectations, update model.
    task automatic cycle(input int g);
        int idx;
        #1;
        o_wait = wreq[g]; o_rdv = rdv[g]; o_rd = rdata[g];
        o_wrc  = wrc[g];  o_rdc = rdc[g]; o_pe = perr[g];
        m_req  = cs[g] && (!read_n || !write_n);
        e_wait = !reset || !(m_req && (m_run >= wait_of(g)));
        e_rdv  = (pend.size() > 0) && (pend[0].due == m_cyc);
        e_rd   = e_rdv ? pend[0].d : 16'h0000;
        if (e_rdv) void'(pend.pop_front());
        e_wrc  = m_wr[g]; e_rdc = m_rd[g]; e_pe = m_pe[g];
        m_acc  = m_req && !e_wait;
        @(posedge clk);
        idx = int'(addr % 64);
        if (m_acc) begin
            if (!write_n) begin
                if (!be_n[0]) m_mem[g][idx][7:0]  = wdata[7:0];
                if (!be_n[1]) m_mem[g][idx][15:8] = wdata[15:8];
                m_wr[g] = m_wr[g] + 16'd1;
                if (!read_n) m_pe[g] = 1'b1;
            end else begin
                pend.push_back('{due: m_cyc + lat_of(g), d: m_mem[g][idx]});
                m_rd[g] = m_rd[g] + 16'd1;
            end
        end
        m_run = (m_req && reset) ? m_run + 1 : 0;
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic run_queue(input int g, input string nm);
        int  guard = 0;
        int  c;
        bit  first = 1'b1;
        st_stall = 0; st_acc = -1; st_rdv = -1; st_rdv_last = -1; st_rdv_n = 0;
        st_first_wait = 1'b1;
        st_data.delete();
        while (((q.size() > 0) || (pend.size() > 0)) && (guard < 600)) begin
            drive_next(g);
            c = m_cyc;
            cycle(g);
            guard++;
            checks++;
            if ({o_wait, o_rdv, o_rd, o_wrc, o_rdc, o_pe} !== {e_wait, e_rdv, e_rd, e_wrc, e_rdc, e_pe}) begin
                errors++;
                $display("FAIL %s dut%0d cyc=%0d got wait=%b valid=%b data=%h wr=%0d rd=%0d perr=%b required wait=%b valid=%b data=%h wr=%0d rd=%0d perr=%b",
                         nm, g, c, o_wait, o_rdv, o_rd, o_wrc, o_rdc, o_pe, e_wait, e_rdv, e_rd, e_wrc, e_rdc, e_pe);
            end
            if (m_req && o_wait) st_stall++;
            if (m_req && first) begin
                st_first_wait = o_wait;
                first = 1'b0;
            end
            if (m_acc && write_n) st_acc = c;
            if (o_rdv) begin
                st_data.push_back(o_rd);
                if (st_rdv < 0) st_rdv = c;
                st_rdv_last = c;
                st_rdv_n++;
            end
            if ((q.size() > 0) && (m_acc || !m_req)) void'(q.pop_front());
        end
        if (guard >= 600) begin
            errors++; checks++;
            $display("FAIL %s timeout: got %0d cycles required fewer than 600", nm, guard);
        end
    endtask

    task automatic test_reset();
        cs = '1; read_n = 1'b0; write_n = 1'b1; addr = 25'd3; be_n = 2'b00; wdata = 16'h0;
        for (int g = 0; g < NI; g++) begin
            cycle(g);
            checks++;
            if ({o_wait, o_rdv, o_rd, o_wrc, o_rdc, o_pe} !== {1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0}) begin
                errors++;
                $display("FAIL reset_state dut%0d got wait=%b valid=%b data=%h wr=%0d rd=%0d perr=%b required 1 0 0000 0 0 0",
                         g, o_wait, o_rdv, o_rd, o_wrc, o_rdc, o_pe);
            end
        end
        cs = '0; read_n = 1'b1;
        reset = 1'b1;
        m_run = 0;
    endtask

    task automatic test_basic();
        q.push_back(mk(1, 0, 1, 25'd3, 2'b00, 16'hA5A5));
        q.push_back(mk(1, 1, 0, 25'd3, 2'b00, 16'h0));
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        run_queue(0, "basic");
        checks++;
        if (st_stall !== 1) begin
            errors++; $display("FAIL basic_stall got %0d required 1", st_stall);
        end
        checks++;
        if ((st_data.size() != 1) || (st_data[0] !== 16'hA5A5)) begin
            errors++; $display("FAIL basic_data got n=%0d %h required n=1 a5a5", st_data.size(), st_data[0]);
        end
        checks++;
        if (st_rdv - st_acc != 2) begin
            errors++; $display("FAIL basic_latency got %0d required 2", st_rdv - st_acc);
        end
        checks++;
        if ((o_wrc !== 16'd1) || (o_rdc !== 16'd1)) begin
            errors++; $display("FAIL basic_counts got wr=%0d rd=%0d required 1 1", o_wrc, o_rdc);
        end
    endtask

    task automatic test_reset_midflight();
        int guard = 0;
        q.push_back(mk(1, 1, 0, 25'd3, 2'b00, 16'h0));
        m_acc = 1'b0;
        while (!m_acc && (guard < 20)) begin
            drive_next(0);
            cycle(0);
            guard++;
        end
        void'(q.pop_front());
        reset = 1'b0;
        model_reset();
        cs = '0; read_n = 1'b1; write_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0);
            checks++;
            if ({o_wait, o_rdv, o_rd, o_wrc, o_rdc, o_pe} !== {1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0}) begin
                errors++;
                $display("FAIL midflight_reset got wait=%b valid=%b data=%h wr=%0d rd=%0d required 1 0 0000 0 0",
                         o_wait, o_rdv, o_rd, o_wrc, o_rdc);
            end
        end
        reset = 1'b1;
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        q.push_back(mk(1, 1, 0, 25'd3, 2'b00, 16'h0));
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        run_queue(0, "post_reset");
        checks++;
        if ((st_data.size() != 1) || (st_data[0] !== 16'hA5A5) || (st_stall != 1)) begin
            errors++;
            $display("FAIL post_reset_read got n=%0d data=%h stall=%0d required n=1 a5a5 stall=1",
                     st_data.size(), st_data[0], st_stall);
        end
    endtask

    task automatic test_byte_enable();
        q.push_back(mk(1, 0, 1, 25'd5, 2'b00, 16'hFFFF));
        q.push_back(mk(1, 0, 1, 25'd5, 2'b01, 16'h1234));
        q.push_back(mk(1, 0, 1, 25'd9, 2'b00, 16'hBEEF));
        q.push_back(mk(1, 0, 1, 25'd9, 2'b11, 16'h0000));
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        q.push_back(mk(1, 1, 0, 25'd5, 2'b00, 16'h0));
        q.push_back(mk(1, 1, 0, 25'd9, 2'b00, 16'h0));
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        run_queue(0, "byte_enable");
        checks++;
        if ((st_data.size() != 2) || (st_data[0] !== 16'h12FF) || (st_data[1] !== 16'hBEEF)) begin
            errors++;
            $display("FAIL byte_enable got n=%0d %h %h required n=2 12ff beef", st_data.size(), st_data[0], st_data[1]);
        end
        checks++;
        if (o_wrc !== 16'd4) begin
            errors++; $display("FAIL be11_counted got wr=%0d required 4", o_wrc);
        end
    endtask

    task automatic test_burst();
        for (int i = 0; i < 16; i++) q.push_back(mk(1, 0, 1, 25'(i), 2'b00, 16'h1000 + 16'(i)));
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        for (int i = 0; i < 16; i++) q.push_back(mk(1, 1, 0, 25'(i), 2'b00, 16'h0));
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        run_queue(0, "burst");
        checks++;
        if (st_stall != 2) begin
            errors++; $display("FAIL burst_stalls got %0d required 2", st_stall);
        end
        checks++;
        if ((st_rdv_n != 16) || (st_rdv_last - st_rdv != 15)) begin
            errors++; $display("FAIL burst_stream got n=%0d span=%0d required 16 15", st_rdv_n, st_rdv_last - st_rdv);
        end
        for (int i = 0; i < 16 && i < st_data.size(); i++) begin
            checks++;
            if (st_data[i] !== 16'h1000 + 16'(i)) begin
                errors++; $display("FAIL burst_data[%0d] got %h required %h", i, st_data[i], 16'h1000 + 16'(i));
            end
        end
    endtask

    task automatic test_proto();
        q.push_back(mk(0, 1, 1, 25'd9, 2'b00, 16'h1111));
        q.push_back(mk(1, 1, 1, 25'h47, 2'b00, 16'h00FF));
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        q.push_back(mk(1, 1, 0, 25'd7, 2'b00, 16'h0));
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        run_queue(0, "proto");
        checks++;
        if (o_pe !== 1'b1) begin
            errors++; $display("FAIL proto_err got %b required 1", o_pe);
        end
        checks++;
        if ((st_data.size() != 1) || (st_data[0] !== 16'h00FF)) begin
            errors++; $display("FAIL proto_alias got n=%0d %h required n=1 00ff", st_data.size(), st_data[0]);
        end
    endtask

    task automatic test_timing(input int g, input int stalls, input int lat, input logic [15:0] d);
        m_run = 0;
        q.push_back(mk(1, 0, 1, 25'd2, 2'b00, d));
        q.push_back(mk(1, 1, 0, 25'd2, 2'b00, 16'h0));
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        run_queue(g, "timing");
        checks++;
        if ((st_stall != stalls) || (st_first_wait !== (stalls != 0))) begin
            errors++;
            $display("FAIL timing_stall dut%0d got %0d first=%b required %0d", g, st_stall, st_first_wait, stalls);
        end
        checks++;
        if ((st_rdv - st_acc != lat) || (st_data.size() != 1) || (st_data[0] !== d)) begin
            errors++;
            $display("FAIL timing_read dut%0d got lat=%0d data=%h required lat=%0d data=%h", g, st_rdv - st_acc, st_data[0], lat, d);
        end
    endtask

    task automatic test_random(input int g, input int n);
        bit   ok [64];
        int   idxs[$];
        int   n_reads = 0;
        int   k;
        int   idx;
        req_t r;
        m_run = 0;
        for (int i = 0; i < 64; i++) ok[i] = 1'b0;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            r = mk(1, 0, 0, 25'($urandom), 2'($urandom), 16'($urandom));
            if ((k <= 3) || ((idxs.size() == 0) && (k <= 6))) begin
                r.wr = 1'b1;
                idx  = int'(r.addr % 64);
                if (!ok[idx]) begin
                    r.be = 2'b00;
                    ok[idx] = 1'b1;
                    idxs.push_back(idx);
                end
            end else if (k <= 6) begin
                r.rd   = 1'b1;
                r.addr = {19'($urandom), 6'(idxs[$urandom_range(0, idxs.size() - 1)])};
                n_reads++;
            end else if (k >= 8) begin
                r.cs = 1'b0;
                r.rd = 1'($urandom);
                r.wr = 1'b1;
            end
            q.push_back(r);
        end
        q.push_back(mk(1, 0, 0, 25'd0, 2'b00, 16'h0));
        run_queue(g, "random");
        checks++;
        if (st_data.size() != n_reads) begin
            errors++; $display("FAIL random_reads dut%0d got %0d required %0d", g, st_data.size(), n_reads);
        end
    endtask

    initial begin
        reset = 1'b0; cs = '0; read_n = 1'b1; write_n = 1'b1;
        addr = '0; be_n = 2'b11; wdata = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_reset_midflight();
        test_byte_enable();
        test_burst();
        test_proto();
        test_timing(1, 0, 1, 16'h5A5A);
        test_timing(2, 3, 4, 16'hC3C3);
        test_random(0, 80);
        test_random(1, 60);
        test_random(2, 60);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion required completion before 1000000");
        $fatal(1);
    end

endmodule

`default_nettype wire
